// File: rtl/block_allocator_pkg.sv
// Shared definitions for the fixed-size block allocator: FSM state encoding,
// default geometry and the flag-word constants for the default RAM width.
package block_allocator_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRIDE = 32;

  // Used flag lives in the top bit of each block's first word.
  localparam int                    FLAG_BIT  = DEF_DATA_W - 1;
  localparam logic [DEF_DATA_W-1:0] USED_WORD = 32'h8000_0000;
  localparam logic [DEF_DATA_W-1:0] FREE_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    IDLE   = 4'd1,
    A_FAIL = 4'd2,
    A_RD   = 4'd3,
    A_CHK  = 4'd4,
    A_WR   = 4'd5,
    F_ERR  = 4'd6,
    F_RD   = 4'd7,
    F_CHK  = 4'd8,
    F_WR   = 4'd9
  } state_e;

endpackage

// File: rtl/block_allocator.sv
// Fixed-size block allocator over an external single-port synchronous RAM.
// Clears every block flag after reset, then serves alloc (next-fit scan with
// wrap-around, block 0 never handed out) and free (with alignment, null and
// double-free detection) through a ready/ack handshake. All outputs are
// registered; the RAM returns read data one cycle after mem_addr is seen.
module block_allocator
  import block_allocator_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               ready,
  input  logic                               alloc_req,
  output logic                               alloc_ack,
  output logic                               alloc_fail,
  output logic [ADDR_W-1:0]                  alloc_addr,
  input  logic                               free_req,
  input  logic [ADDR_W-1:0]                  free_addr,
  output logic                               free_ack,
  output logic                               free_err,
  output logic [ADDR_W-$clog2(STRIDE)-1:0]   free_count,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  output logic                               mem_wren,
  input  logic [DATA_W-1:0]                  mem_rdata
);

  localparam int OFF_W      = $clog2(STRIDE);
  localparam int BLK_W      = ADDR_W - OFF_W;
  localparam int NUM_BLOCKS = 2 ** BLK_W;
  localparam int FLAG_IDX   = DATA_W - 1;

  localparam logic [BLK_W-1:0]  FIRST_BLK = BLK_W'(1);
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(STRIDE - 1);
  localparam logic [DATA_W-1:0] USED_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FREE_VAL  = {DATA_W{1'b0}};

  state_e              state_q;
  logic                ready_q;
  logic                alloc_ack_q;
  logic                alloc_fail_q;
  logic [ADDR_W-1:0]   alloc_addr_q;
  logic                free_ack_q;
  logic                free_err_q;
  logic [BLK_W-1:0]    free_count_q;
  logic [BLK_W-1:0]    ptr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_wren_q;

  logic [BLK_W-1:0]    ptr_next_s;
  logic [ADDR_W-1:0]   ptr_base_s;
  logic [ADDR_W-1:0]   next_base_s;
  logic                free_bad_s;
  logic                unused_rdata_s;

  // Only the flag bit of a block's first word is meaningful here.
  assign unused_rdata_s = ^mem_rdata[DATA_W-2:0];

  // Pointer successor (wraps past the last block back to 1, skipping the
  // null block), base addresses, and the immediate free-address checks.
  always_comb begin
    if (ptr_q == LAST_BLK) begin
      ptr_next_s = FIRST_BLK;
    end else begin
      ptr_next_s = ptr_q + FIRST_BLK;
    end
    ptr_base_s  = ADDR_W'(ptr_q) << OFF_W;
    next_base_s = ADDR_W'(ptr_next_s) << OFF_W;
    free_bad_s  = ((free_addr & OFF_MASK) != '0) || ((free_addr >> OFF_W) == '0);
  end

  // Main controller: flag clearing, request arbitration, scan and free paths.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      ready_q      <= 1'b0;
      alloc_ack_q  <= 1'b0;
      alloc_fail_q <= 1'b0;
      alloc_addr_q <= '0;
      free_ack_q   <= 1'b0;
      free_err_q   <= 1'b0;
      free_count_q <= '0;
      ptr_q        <= FIRST_BLK;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
    end else begin
      alloc_ack_q <= 1'b0;
      free_ack_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      case (state_q)
        INIT: begin
          // ptr doubles as the clear index; it ends back at block 1.
          mem_addr_q  <= ptr_base_s;
          mem_wdata_q <= FREE_VAL;
          mem_wren_q  <= 1'b1;
          ptr_q       <= ptr_next_s;
          if (ptr_q == LAST_BLK) begin
            free_count_q <= LAST_BLK;
            state_q      <= IDLE;
          end
        end
        IDLE: begin
          if (!ready_q) begin
            // Cycle after an ack (or after clearing): just reopen.
            ready_q <= 1'b1;
          end else if (free_req) begin
            ready_q    <= 1'b0;
            mem_addr_q <= free_addr;
            state_q    <= free_bad_s ? F_ERR : F_RD;
          end else if (alloc_req) begin
            ready_q <= 1'b0;
            if (free_count_q == '0) begin
              state_q <= A_FAIL;
            end else begin
              mem_addr_q <= ptr_base_s;
              state_q    <= A_RD;
            end
          end
        end
        A_FAIL: begin
          alloc_ack_q  <= 1'b1;
          alloc_fail_q <= 1'b1;
          state_q      <= IDLE;
        end
        A_RD: begin
          state_q <= A_CHK;
        end
        A_CHK: begin
          if (!mem_rdata[FLAG_IDX]) begin
            mem_wdata_q <= USED_VAL;
            mem_wren_q  <= 1'b1;
            state_q     <= A_WR;
          end else begin
            ptr_q      <= ptr_next_s;
            mem_addr_q <= next_base_s;
            state_q    <= A_RD;
          end
        end
        A_WR: begin
          alloc_ack_q  <= 1'b1;
          alloc_fail_q <= 1'b0;
          alloc_addr_q <= mem_addr_q;
          free_count_q <= free_count_q - FIRST_BLK;
          ptr_q        <= ptr_next_s;
          state_q      <= IDLE;
        end
        F_ERR: begin
          free_ack_q <= 1'b1;
          free_err_q <= 1'b1;
          state_q    <= IDLE;
        end
        F_RD: begin
          state_q <= F_CHK;
        end
        F_CHK: begin
          if (mem_rdata[FLAG_IDX]) begin
            mem_wdata_q <= FREE_VAL;
            mem_wren_q  <= 1'b1;
            state_q     <= F_WR;
          end else begin
            // Block already free: report a double free without writing.
            free_ack_q <= 1'b1;
            free_err_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        F_WR: begin
          free_ack_q   <= 1'b1;
          free_err_q   <= 1'b0;
          free_count_q <= free_count_q + FIRST_BLK;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= INIT;
          ready_q      <= 1'b0;
          free_count_q <= '0;
          ptr_q        <= FIRST_BLK;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign alloc_ack  = alloc_ack_q;
  assign alloc_fail = alloc_fail_q;
  assign alloc_addr = alloc_addr_q;
  assign free_ack   = free_ack_q;
  assign free_err   = free_err_q;
  assign free_count = free_count_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;

endmodule
